// File: rtl/ghostbus_host_arb_pkg.sv
// Shared types and elaboration helpers for the ghostbus host arbiter.
package ghostbus_host_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } state_e;

   localparam int unsigned RlatMin = 1;
   localparam int unsigned RlatMax = 4;
   localparam int unsigned NreqMin = 2;
   localparam int unsigned NreqMax = 8;

   function automatic bit rlat_ok(input int unsigned rlat);
      return (rlat >= RlatMin) && (rlat <= RlatMax);
   endfunction

   function automatic bit nreq_ok(input int unsigned nreq);
      return (nreq >= NreqMin) && (nreq <= NreqMax);
   endfunction

endpackage

// File: rtl/ghostbus_host_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module ghostbus_host_arb_rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [31:0]   cand;
   logic [IW-1:0] cand_idx;
   logic          found;

   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = '0;
      cand_idx = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand     = (32'(ptr_i) + k) % N;
         cand_idx = IW'(cand);
         if (!found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/ghostbus_host_arb.sv
// Round-robin arbiter sharing one ghostbus host port between NREQ single-beat requesters.
module ghostbus_host_arb
   import ghostbus_host_arb_pkg::*;
#(
   parameter int unsigned AW   = 24,
   parameter int unsigned DW   = 32,
   parameter int unsigned NREQ = 2,
   parameter int unsigned RLAT = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_valid_i,
   output logic [NREQ-1:0]    req_ready_o,
   input  logic [NREQ-1:0]    req_we_i,
   input  logic [NREQ*AW-1:0] req_addr_i,
   input  logic [NREQ*DW-1:0] req_wdata_i,
   output logic [NREQ-1:0]    rsp_valid_o,
   output logic [DW-1:0]      rsp_rdata_o,
   output logic [AW-1:0]      gb_addr_o,
   output logic [DW-1:0]      gb_wdata_o,
   output logic               gb_we_o,
   output logic               gb_re_o,
   input  logic [DW-1:0]      gb_rdata_i,
   output logic               busy_o
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (!rlat_ok(RLAT)) begin : gen_rlat_check
      $error("ghostbus_host_arb: RLAT must be within 1..4");
   end
   if (!nreq_ok(NREQ)) begin : gen_nreq_check
      $error("ghostbus_host_arb: NREQ must be within 2..8");
   end

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   ghostbus_host_arb_rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_rr_pick (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // One-hot mux of the winning requester's command fields.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_gnt[i]) begin
            sel_we    = req_we_i[i];
            sel_addr  = req_addr_i[i*AW +: AW];
            sel_wdata = req_wdata_i[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      rsp_valid_d = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               ptr_d   = pick_idx;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (we_q) begin
               rsp_valid_d = NREQ'(1) << ptr_q;
               state_d     = StIdle;
            end else begin
               cnt_d   = 3'(RLAT);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 3'd1) begin
               rdata_d     = gb_rdata_i;
               rsp_valid_d = NREQ'(1) << ptr_q;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         ptr_q       <= IW'(NREQ - 1);
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Ready is combinational from the picker, so it must be masked while reset is held.
   assign req_ready_o = (state_q == StIdle && !rst_i) ? pick_gnt : '0;
   assign gb_we_o     = (state_q == StIssue) && we_q;
   assign gb_re_o     = (state_q == StIssue) && !we_q;
   assign gb_addr_o   = addr_q;
   assign gb_wdata_o  = wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/ghostbus_host_arb.md
Name: ghostbus_host_arb

Overview:
- Shares one ghostbus host port between NREQ independent requesters, e.g. a UART bridge, a UDP bridge and an on-chip sequencer.
- Accepts single-beat read/write requests over valid/ready, grants them round-robin, and drives exactly one ghostbus strobe per transaction.
- Returns read data after a fixed bus read latency; only one transaction is outstanding at a time.
- Sits between the host bridges and the top-level ghostbus decoder.

Parameters:
- AW, 24, ghostbus address width.
- DW, 32, ghostbus data width.
- NREQ, 2, number of requesters (2..8).
- RLAT, 1, cycles from gb_re to valid gb_rdata (1..4).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DW  read data, shared by all requesters; qualified by rsp_valid.
- gb_addr  out  AW  ghostbus address.
- gb_wdata  out  DW  ghostbus write data.
- gb_we  out  1  ghostbus write strobe.
- gb_re  out  1  ghostbus read strobe.
- gb_rdata  in  DW  ghostbus read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst high): the following clear to 0 immediately:
  - all outputs;
  - state = IDLE;
  - round-robin pointer = NREQ-1, so requester 0 wins first.
- A transaction in flight at reset is dropped silently, with no rsp_valid. The requester reissues.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high, pick the winner g: first set bit searching from ptr+1 upward, wrapping modulo NREQ.
  - req_ready[g] = 1 combinationally in this cycle; this is the accept.
  - Latch addr/wdata/we of g; ptr <= g; next state ISSUE.
  - If no valid is high, stay in IDLE; req_ready = 0.
- ISSUE (exactly 1 cycle):
  - gb_addr and gb_wdata come from the latch.
  - Write: gb_we = 1, next state IDLE.
  - Read: gb_re = 1, next state WAIT.
- WAIT:
  - Down-counter loaded with RLAT; gb_rdata is sampled in the cycle where the counter reaches 1, i.e. exactly RLAT cycles after the gb_re cycle.
  - Sampled data is registered into rsp_rdata; next state IDLE.
- Responses are registered:
  - rsp_valid[g] pulses for 1 cycle in the first IDLE cycle after the transaction ends.
  - A new grant may be issued in that same cycle.
- Latency from the accept cycle (T0):
  - Write: gb_we at T0+1, rsp_valid at T0+2.
  - Read: gb_re at T0+1, rsp_valid at T0+2+RLAT.
- Throughput: one write per 2 cycles, one read per 2+RLAT cycles.
- Idle bus values:
  - gb_we and gb_re are 0 outside ISSUE.
  - gb_addr and gb_wdata hold their last values.
  - rsp_rdata holds the last read data; a write completion does not modify it.
- Requesters must hold valid/addr/wdata/we stable until ready. Deasserting before ready is allowed; that request is simply not granted.
- Simultaneous requests are fully decided by the round-robin pointer. No requester waits more than NREQ-1 grants while its valid is held.
- A requester may reassert valid in the cycle its rsp_valid pulses and competes normally.
- Invariants: gb_we and gb_re are never high together; at most one bit of req_ready and of rsp_valid is high.

Decomposition:
- Shared header ghostbus_arb_defs.vh holds:
  - state encodings IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  - the RLAT range check (elaboration error if RLAT < 1 or RLAT > 4).
- One sub-module, ghostbus_rr_pick: purely combinational.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, binary index, any-request flag.
  - Reused by future bus schedulers.

Test Plan:
- Single write, NREQ=2, RLAT=1: req0 writes addr 0x000040, data 0x5A at T0.
  - Required: ready0 at T0; gb_we=1 with addr 0x40, wdata 0x5A at T0+1; rsp_valid=2'b01 at T0+2; rsp_rdata unchanged.
- Single read, RLAT=3: req1 reads 0x000010; model drives 0x42 on gb_rdata exactly 3 cycles after gb_re.
  - Required: rsp_valid=2'b10 at T0+5, rsp_rdata=0x42.
- Contention, NREQ=3, all valids held high, reads of distinct addresses.
  - Required: grant order 0,1,2,0,1,2; gb_re never overlaps gb_we; no requester starves.
- Back-to-back: req0 reasserts valid in its rsp_valid cycle while req1 also requests.
  - Required: req1 is granted in that cycle (pointer moved past 0).
- Async reset asserted in WAIT.
  - Required: busy, gb_re, rsp_valid and req_ready fall to 0 without a clock edge; no response after release; the next grant goes to requester 0.
- Idle/hold: no requests for 20 cycles.
  - Required: gb_we=gb_re=0, busy=0, gb_addr holds its last value.
